// File: rtl/card_disp_pkg.sv
// Shared colours, ROM address widths and the side-band record for the card-grid renderer.
package card_disp_pkg;
  localparam logic [11:0] FRAME_COLOR = 12'hFD3;
  localparam logic [11:0] BG_COLOR    = 12'h000;
  localparam int TYPE_W_DEF = 6;
  localparam int PX_W       = 6;
  localparam int PY_W       = 6;
  localparam int RGB_W      = 12;

  typedef struct packed {
    logic            valid;
    logic            in_card;
    logic            sel;
    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;
  } sband_t;

  function automatic logic on_frame(input logic [PX_W-1:0] px, input logic [PY_W-1:0] py,
                                    input int cell_w, input int card_h, input int frame_w);
    return (int'(px) < frame_w) || (int'(px) >= cell_w - frame_w) ||
           (int'(py) < frame_w) || (int'(py) >= card_h - frame_w);
  endfunction
endpackage

// File: rtl/card_cell_locator.sv
// Combinational scan-position to grid-cell mapping for the two vertical card bands.
module card_cell_locator
  import card_disp_pkg::*;
#(
  parameter int COLS     = 18,
  parameter int ROWS     = 8,
  parameter int TOP_ROWS = 6,
  parameter int X0       = 32,
  parameter int Y0_TOP   = 19,
  parameter int Y0_BOT   = 360,
  parameter int CELL_W   = 32,
  parameter int CELL_H   = 55,
  parameter int CARD_H   = 46,
  parameter int COL_W    = $clog2(COLS),
  parameter int ROW_W    = $clog2(ROWS)
) (
  input  logic [9:0]       i_h,
  input  logic [9:0]       i_v,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic [PX_W-1:0]  o_px,
  output logic [PY_W-1:0]  o_py,
  output logic             o_in_card
);
  localparam int X_END  = X0 + COLS * CELL_W;
  localparam int YT_END = Y0_TOP + TOP_ROWS * CELL_H;
  localparam int YB_END = Y0_BOT + (ROWS - TOP_ROWS) * CELL_H;

  logic       w_in_x, w_in_top, w_in_bot;
  logic [9:0] w_hx, w_vy, w_col, w_rrel, w_py;

  assign w_in_x   = (int'(i_h) >= X0) && (int'(i_h) < X_END);
  assign w_in_top = (int'(i_v) >= Y0_TOP) && (int'(i_v) < YT_END);
  assign w_in_bot = (int'(i_v) >= Y0_BOT) && (int'(i_v) < YB_END);

  // Offsets only meaningful when inside; the final mux zeroes everything otherwise.
  assign w_hx   = i_h - 10'(X0);
  assign w_col  = w_hx / 10'(CELL_W);
  assign w_vy   = w_in_top ? (i_v - 10'(Y0_TOP)) : (i_v - 10'(Y0_BOT));
  assign w_rrel = w_vy / 10'(CELL_H);
  assign w_py   = w_vy - w_rrel * 10'(CELL_H);

  always_comb begin
    o_col     = '0;
    o_row     = '0;
    o_px      = '0;
    o_py      = '0;
    o_in_card = 1'b0;
    if (w_in_x && (w_in_top || w_in_bot)) begin
      o_col     = COL_W'(w_col);
      o_row     = w_in_top ? ROW_W'(w_rrel) : ROW_W'(w_rrel + 10'(TOP_ROWS));
      o_px      = PX_W'(w_hx - w_col * 10'(CELL_W));
      o_py      = PY_W'(w_py);
      o_in_card = int'(w_py) < CARD_H;
    end
  end
endmodule

// File: rtl/card_grid_renderer.sv
// Pipelined card-grid pixel generator: locate cell, fetch card ROM, overlay highlight frame.
// Optional macro CARD_BLINK_EN adds a frame counter that blinks the highlight frame.
module card_grid_renderer
  import card_disp_pkg::*;
#(
  parameter int COLS      = 18,
  parameter int ROWS      = 8,
  parameter int TOP_ROWS  = 6,
  parameter int TYPE_W    = TYPE_W_DEF,
  parameter int X0        = 32,
  parameter int Y0_TOP    = 19,
  parameter int Y0_BOT    = 360,
  parameter int CELL_W    = 32,
  parameter int CELL_H    = 55,
  parameter int CARD_H    = 46,
  parameter int FRAME_W   = 2,
  parameter int ROM_LAT   = 1,
  parameter int BLINK_BIT = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_en,
  input  logic [9:0]                    h_cnt,
  input  logic [9:0]                    v_cnt,
  input  logic [ROWS*COLS*TYPE_W-1:0]   map,
  input  logic [ROWS*COLS-1:0]          sel_card,
  output logic [TYPE_W-1:0]             rom_card_type,
  output logic [PX_W-1:0]               rom_px,
  output logic [PY_W-1:0]               rom_py,
  input  logic [RGB_W-1:0]              rom_pixel,
  output logic [RGB_W-1:0]              card_pixel,
  output logic                          card_valid
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int IDX_W = $clog2(ROWS * COLS);

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [PX_W-1:0]  w_px;
  logic [PY_W-1:0]  w_py;
  logic             w_in_card;

  card_cell_locator #(
    .COLS(COLS), .ROWS(ROWS), .TOP_ROWS(TOP_ROWS), .X0(X0), .Y0_TOP(Y0_TOP),
    .Y0_BOT(Y0_BOT), .CELL_W(CELL_W), .CELL_H(CELL_H), .CARD_H(CARD_H),
    .COL_W(COL_W), .ROW_W(ROW_W)
  ) u_loc (
    .i_h(h_cnt), .i_v(v_cnt), .o_col(w_col), .o_row(w_row),
    .o_px(w_px), .o_py(w_py), .o_in_card(w_in_card)
  );

  // S1
  logic             r_s1_vld, r_s1_in;
  logic [COL_W-1:0] r_s1_col;
  logic [ROW_W-1:0] r_s1_row;
  logic [PX_W-1:0]  r_s1_px;
  logic [PY_W-1:0]  r_s1_py;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_in  <= 1'b0;
      r_s1_col <= '0;
      r_s1_row <= '0;
      r_s1_px  <= '0;
      r_s1_py  <= '0;
    end else begin
      r_s1_vld <= pix_en;
      r_s1_in  <= w_in_card;
      r_s1_col <= w_col;
      r_s1_row <= w_row;
      r_s1_px  <= w_px;
      r_s1_py  <= w_py;
    end
  end

  // S2: map/sel_card are sampled here, which is the ROM address cycle
  logic [IDX_W-1:0]  w_idx;
  logic [TYPE_W-1:0] r_type;
  sband_t            r_s2;

  assign w_idx = IDX_W'(int'(r_s1_row) * COLS + int'(r_s1_col));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type <= '0;
      r_s2   <= '0;
    end else begin
      r_type       <= map[int'(w_idx)*TYPE_W +: TYPE_W];
      r_s2.valid   <= r_s1_vld;
      r_s2.in_card <= r_s1_in;
      r_s2.sel     <= sel_card[w_idx];
      r_s2.px      <= r_s1_px;
      r_s2.py      <= r_s1_py;
    end
  end

  assign rom_card_type = r_type;
  assign rom_px        = r_s2.px;
  assign rom_py        = r_s2.py;

  // Side-band delay line aligns with rom_pixel
  sband_t r_dly [ROM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ROM_LAT; k++) r_dly[k] <= '0;
    end else begin
      r_dly[0] <= r_s2;
      for (int k = 1; k < ROM_LAT; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  logic w_frame_on;
`ifdef CARD_BLINK_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_frame_cnt <= '0;
    else if (pix_en && h_cnt == '0 && v_cnt == '0)  r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign w_frame_on = ~r_frame_cnt[BLINK_BIT];
`else
  // Frame always drawn; BLINK_BIT is referenced only to keep the parameter list uniform.
  assign w_frame_on = (BLINK_BIT >= 0);
`endif

  sband_t w_tail;
  assign w_tail = r_dly[ROM_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_pixel <= '0;
      card_valid <= 1'b0;
    end else begin
      card_valid <= w_tail.valid;
      if (!w_tail.in_card)
        card_pixel <= BG_COLOR;
      else if (w_tail.sel && w_frame_on && on_frame(w_tail.px, w_tail.py, CELL_W, CARD_H, FRAME_W))
        card_pixel <= FRAME_COLOR;
      else
        card_pixel <= rom_pixel;
    end
  end
endmodule
